// File: rtl/adc_pkg.sv
// Shared FSM type, frame geometry and default channel map for the
// ADC128S022 line-sensor reader.
package adc_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  localparam int FRAME_BITS   = 16;
  localparam int DATA_BITS    = 12;
  localparam int ADDR_MSB_BIT = 2;

  localparam logic [2:0] DEF_CH_LEFT   = 3'd0;
  localparam logic [2:0] DEF_CH_CENTER = 3'd1;
  localparam logic [2:0] DEF_CH_RIGHT  = 3'd2;

  // Control word bit driven on MOSI at frame position idx: ADD2..ADD0 sit
  // at ADDR_MSB_BIT and the two positions after it, everything else is 0.
  function automatic logic frame_bit(input logic [2:0] ch, input logic [3:0] idx);
    logic [3:0] msb;
    msb = 4'(ADDR_MSB_BIT);
    frame_bit = 1'b0;
    if (idx == msb)              frame_bit = ch[2];
    else if (idx == msb + 4'd1)  frame_bit = ch[1];
    else if (idx == msb + 4'd2)  frame_bit = ch[0];
  endfunction

endpackage

// File: rtl/adc_sclk_div.sv
// SCLK half-period timer: while run is high, alternates a fall strobe and a
// rise strobe every HALF_DIV clks, starting with a fall.
module adc_sclk_div #(
  parameter int HALF_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int CW = (HALF_DIV > 2) ? $clog2(HALF_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

  logic [CW-1:0] cnt;
  logic          high_next;

  always_comb begin
    fall_stb = run && (cnt == LAST) && !high_next;
    rise_stb = run && (cnt == LAST) && high_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      high_next <= 1'b0;
    end else if (!run) begin
      cnt       <= '0;
      high_next <= 1'b0;
    end else if (cnt == LAST) begin
      cnt       <= '0;
      high_next <= ~high_next;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_sensor_reader.sv
// SPI master for the ADC128S022: scans left/center/right round-robin and
// holds the latest 12-bit reading of each as a registered output.
module adc_sensor_reader
  import adc_pkg::*;
#(
  parameter int         HALF_DIV   = 8,
  parameter int         GAP_CYCLES = 16,
  parameter logic [2:0] CH_LEFT    = DEF_CH_LEFT,
  parameter logic [2:0] CH_CENTER  = DEF_CH_CENTER,
  parameter logic [2:0] CH_RIGHT   = DEF_CH_RIGHT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 adc_dout,
  output logic                 adc_cs_n,
  output logic                 adc_sck,
  output logic                 adc_din,
  output logic [DATA_BITS-1:0] left_sensor,
  output logic [DATA_BITS-1:0] center_sensor,
  output logic [DATA_BITS-1:0] right_sensor,
  output logic                 sample_valid
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [3:0]    LAST_BIT = 4'(FRAME_BITS - 1);

  state_t               state;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic [GW-1:0]        gap_cnt;
  logic                 write_pend;
  logic                 first_frame;
  logic [2:0]           ptr;
  logic [2:0]           prev_ch;
  logic                 run;
  logic                 fall_stb;
  logic                 rise_stb;

  function automatic logic [2:0] next_ch(input logic [2:0] c);
    if (c == CH_LEFT)        next_ch = CH_CENTER;
    else if (c == CH_CENTER) next_ch = CH_RIGHT;
    else                     next_ch = CH_LEFT;
  endfunction

  always_comb run = (state == SETUP) || (state == SHIFT);

  adc_sclk_div #(.HALF_DIV(HALF_DIV)) u_div (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      adc_cs_n      <= 1'b1;
      adc_sck       <= 1'b1;
      adc_din       <= 1'b0;
      left_sensor   <= '0;
      center_sensor <= '0;
      right_sensor  <= '0;
      sample_valid  <= 1'b0;
      bit_idx       <= '0;
      shreg         <= '0;
      gap_cnt       <= '0;
      write_pend    <= 1'b0;
      first_frame   <= 1'b1;
      ptr           <= CH_LEFT;
      prev_ch       <= CH_LEFT;
    end else begin
      sample_valid <= 1'b0;
      write_pend   <= 1'b0;

      // The ADC answers one frame late, so this frame's data belongs to prev_ch.
      if (write_pend) begin
        if (!first_frame) begin
          if (prev_ch == CH_LEFT) begin
            left_sensor <= shreg;
          end else if (prev_ch == CH_CENTER) begin
            center_sensor <= shreg;
          end else if (prev_ch == CH_RIGHT) begin
            right_sensor <= shreg;
            sample_valid <= 1'b1;
          end
        end
        first_frame <= 1'b0;
        prev_ch     <= ptr;
        ptr         <= next_ch(ptr);
      end

      case (state)
        IDLE: begin
          if (en) begin
            adc_cs_n <= 1'b0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (fall_stb) begin
            adc_sck <= 1'b0;
            adc_din <= frame_bit(ptr, 4'd0);
            bit_idx <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // The 4 leading zero bits simply shift out of the top of shreg.
          if (rise_stb) begin
            adc_sck <= 1'b1;
            shreg   <= {shreg[DATA_BITS-2:0], adc_dout};
            if (bit_idx == LAST_BIT) write_pend <= 1'b1;
          end else if (fall_stb) begin
            if (bit_idx == LAST_BIT) begin
              adc_cs_n <= 1'b1;
              gap_cnt  <= '0;
              state    <= GAP;
            end else begin
              adc_sck <= 1'b0;
              adc_din <= frame_bit(ptr, bit_idx + 4'd1);
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (en) begin
              adc_cs_n <= 1'b0;
              state    <= SETUP;
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sensor_reader.sv
// Bench for adc_sensor_reader: two instances (default timing and HALF_DIV=2,
// GAP_CYCLES=1) against a behavioural ADC + output model.
module tb_adc_sensor_reader;

  localparam int FLEN0 = 280;
  localparam int FLEN1 = 67;

  // clock / reset
  logic clk = 1'b0;
  always #10 clk = ~clk;
  logic rst = 1'b1;
  logic en  = 1'b0;

  logic        dout   [2];
  logic        cs_n   [2];
  logic        sck    [2];
  logic        din    [2];
  logic        sv     [2];
  logic [11:0] left_s [2];
  logic [11:0] cent_s [2];
  logic [11:0] right_s[2];

  adc_sensor_reader #(.HALF_DIV(8), .GAP_CYCLES(16)) dut0 (
    .clk(clk), .rst(rst), .en(en), .adc_dout(dout[0]), .adc_cs_n(cs_n[0]),
    .adc_sck(sck[0]), .adc_din(din[0]), .left_sensor(left_s[0]),
    .center_sensor(cent_s[0]), .right_sensor(right_s[0]), .sample_valid(sv[0])
  );

  adc_sensor_reader #(.HALF_DIV(2), .GAP_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .adc_dout(dout[1]), .adc_cs_n(cs_n[1]),
    .adc_sck(sck[1]), .adc_din(din[1]), .left_sensor(left_s[1]),
    .center_sensor(cent_s[1]), .right_sensor(right_s[1]), .sample_valid(sv[1])
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ADC conversion results per channel, set by the stimulus
  logic [11:0] adc_tab [8];
  logic        period_chk = 1'b0;

  // behavioural model state
  int          cyc = 0;
  int          frames [2];
  int          fall_n [2];
  int          rise_n [2];
  int          sv_cnt [2];
  int          last_fall [2];
  int          last_sv [2];
  logic        lf_valid [2];
  logic        sv_valid [2];
  logic [15:0] tx_word [2];
  logic [15:0] din_bits [2];
  logic [2:0]  adc_addr [2];
  logic [11:0] exp_s [2][3];
  logic        exp_sv [2];
  logic        cs_p [2];
  logic        sck_p [2];
  logic        din_p [2];

  function automatic int flen(input int i);
    return (i == 0) ? FLEN0 : FLEN1;
  endfunction

  function automatic logic [15:0] exp_din(input logic [2:0] a);
    logic [15:0] w;
    w = 16'h0;
    w[2] = a[2];
    w[3] = a[1];
    w[4] = a[0];
    return w;
  endfunction

  initial begin
    adc_addr[0] = 3'd0;
    adc_addr[1] = 3'd0;
  end

  // ADC model and per-cycle scoreboard
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        frames[i] = 0; fall_n[i] = 0; rise_n[i] = 0; sv_cnt[i] = 0;
        lf_valid[i] = 1'b0; sv_valid[i] = 1'b0; exp_sv[i] = 1'b0; dout[i] = 1'b0;
        for (int c = 0; c < 3; c++) exp_s[i][c] = 12'd0;
      end else begin
        chk($sformatf("dut%0d_left", i),   left_s[i],  exp_s[i][0]);
        chk($sformatf("dut%0d_center", i), cent_s[i],  exp_s[i][1]);
        chk($sformatf("dut%0d_right", i),  right_s[i], exp_s[i][2]);
        chk($sformatf("dut%0d_sample_valid", i), sv[i], exp_sv[i]);
        if (sv[i]) begin
          sv_cnt[i]++;
          if (period_chk && sv_valid[i])
            chk($sformatf("dut%0d_sv_period", i), cyc - last_sv[i], 3 * flen(i));
          last_sv[i]  = cyc;
          sv_valid[i] = period_chk;
        end
        if (din[i] !== din_p[i])
          chk($sformatf("dut%0d_din_on_fall", i), {sck_p[i], sck[i]}, 2'b10);
        if (sck[i] !== sck_p[i])
          chk($sformatf("dut%0d_sck_needs_cs", i), cs_n[i], 1'b0);
        exp_sv[i] = 1'b0;

        if (cs_p[i] && !cs_n[i]) begin
          if (period_chk && lf_valid[i])
            chk($sformatf("dut%0d_frame_len", i), cyc - last_fall[i], flen(i));
          last_fall[i] = cyc;
          lf_valid[i]  = period_chk;
          fall_n[i] = 0;
          rise_n[i] = 0;
          din_bits[i] = 16'h0;
          tx_word[i] = {4'h0, adc_tab[adc_addr[i]]};
        end
        if (!cs_n[i] && sck_p[i] && !sck[i]) begin
          fall_n[i]++;
          if (fall_n[i] <= 16) dout[i] = tx_word[i][16 - fall_n[i]];
        end
        if (!cs_n[i] && !sck_p[i] && sck[i]) begin
          rise_n[i]++;
          if (rise_n[i] <= 16) din_bits[i][rise_n[i] - 1] = din[i];
          if (rise_n[i] == 16) begin
            chk($sformatf("dut%0d_din_frame", i), din_bits[i], exp_din(3'(frames[i] % 3)));
            if (frames[i] > 0) begin
              exp_s[i][(frames[i] - 1) % 3] = tx_word[i][11:0];
              exp_sv[i] = ((frames[i] - 1) % 3) == 2;
            end
            adc_addr[i] = {din_bits[i][2], din_bits[i][3], din_bits[i][4]};
            frames[i]++;
          end
        end
      end
      cs_p[i]  = cs_n[i];
      sck_p[i] = sck[i];
      din_p[i] = din[i];
    end
  end

  // driver tasks
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_frames(input int n);
    int b = 0;
    while (frames[0] < n && b < 20000) begin
      @(posedge clk);
      b++;
    end
    if (frames[0] < n) chk("wait_frames_timeout", frames[0], n);
  endtask

  task automatic wait_fall(input int k);
    int b = 0;
    while (!(fall_n[0] == k && !cs_n[0]) && b < 2000) begin
      @(posedge clk);
      b++;
    end
    if (fall_n[0] != k) chk("wait_fall_timeout", fall_n[0], k);
  endtask

  initial begin
    int t;
    int bad;
    for (int c = 0; c < 8; c++) adc_tab[c] = 12'hABC;
    en = 1'b1;
    wait_clks(3);
    #2 rst = 1'b0;

    // first frame discarded, then left, center, right fill in
    wait_frames(1); wait_clks(4);
    chk("s1_left_after_f1", left_s[0], 12'h000);
    wait_frames(2); wait_clks(4);
    chk("s1_left_after_f2", left_s[0], 12'hABC);
    chk("s1_center_after_f2", cent_s[0], 12'h000);
    wait_frames(5);
    chk("s1_left", left_s[0], 12'hABC);
    chk("s1_center", cent_s[0], 12'hABC);
    chk("s1_right", right_s[0], 12'hABC);
    chk("s1_sv_count", sv_cnt[0], 1);
    chk("s1_fast_right", right_s[1], 12'hABC);

    // per-channel values, steady-state timing
    adc_tab[0] = 12'd500; adc_tab[1] = 12'd3000; adc_tab[2] = 12'd120;
    period_chk = 1'b1;
    t = frames[0] + 9;
    wait_frames(t);
    period_chk = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("s3_dut%0d_left", i), left_s[i], 12'd500);
      chk($sformatf("s3_dut%0d_center", i), cent_s[i], 12'd3000);
      chk($sformatf("s3_dut%0d_right", i), right_s[i], 12'd120);
    end

    // en dropped mid-frame: frame finishes, then parks
    wait_fall(8);
    #2 en = 1'b0;
    t = frames[0] + 1;
    bad = 0;
    while (cs_n[0] !== 1'b1 && bad < 2000) begin
      @(posedge clk);
      bad++;
    end
    chk("s4_frame_completed", frames[0], t);
    bad = 0;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (cs_n[0] !== 1'b1 || sck[0] !== 1'b1 || cs_n[1] !== 1'b1 || sck[1] !== 1'b1) bad++;
    end
    chk("s4_parked_idle_cycles_bad", bad, 0);
    #1 en = 1'b1;
    t = frames[0] + 4;
    wait_frames(t); wait_clks(4);
    chk("s4_left", left_s[0], 12'd500);
    chk("s4_center", cent_s[0], 12'd3000);
    chk("s4_right", right_s[0], 12'd120);

    // asynchronous reset mid-frame
    wait_fall(10);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("s5_dut%0d_cs_n", i), cs_n[i], 1'b1);
      chk($sformatf("s5_dut%0d_sck", i), sck[i], 1'b1);
      chk($sformatf("s5_dut%0d_din", i), din[i], 1'b0);
      chk($sformatf("s5_dut%0d_left", i), left_s[i], 12'd0);
      chk($sformatf("s5_dut%0d_center", i), cent_s[i], 12'd0);
      chk($sformatf("s5_dut%0d_right", i), right_s[i], 12'd0);
      chk($sformatf("s5_dut%0d_sv", i), sv[i], 1'b0);
    end
    wait_clks(2);
    #2 rst = 1'b0;
    wait_frames(1); wait_clks(4);
    chk("s5_left_after_f1", left_s[0], 12'd0);
    wait_frames(2); wait_clks(4);
    chk("s5_left_after_f2", left_s[0], 12'd500);
    wait_frames(4); wait_clks(4);
    chk("s5_center", cent_s[0], 12'd3000);
    chk("s5_right", right_s[0], 12'd120);
    chk("s5_sv_count", sv_cnt[0], 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
